// File: rtl/noc_test_node_pkg.sv
// Shared NoC test-node definitions: flit field layout, coordinate width,
// body pattern, TX state encoding and flit builder helpers.
package noc_test_node_pkg;

  localparam int NOC_DATA_WIDTH = 32;
  localparam int COORD_W        = 4;

  // Header flit field positions (LSB of each field)
  localparam int HDR_DST_X_LSB = 0;
  localparam int HDR_DST_Y_LSB = 4;
  localparam int HDR_SRC_X_LSB = 8;
  localparam int HDR_SRC_Y_LSB = 12;
  localparam int HDR_LEN_LSB   = 16;
  localparam int HDR_SEQ_LSB   = 24;

  // Constant carried in the top half of every body flit
  localparam logic [15:0] BODY_PATTERN = 16'hA5A5;

  typedef enum logic [2:0] {
    TX_IDLE = 3'd0,
    TX_HEAD = 3'd1,
    TX_BODY = 3'd2,
    TX_GAP  = 3'd3,
    TX_DONE = 3'd4
  } tx_state_e;

  // Low 32 bits of a header flit; wider flits are zero-extended by the caller.
  function automatic logic [31:0] make_header(
    input logic [COORD_W-1:0] dst_x,
    input logic [COORD_W-1:0] dst_y,
    input logic [COORD_W-1:0] src_x,
    input logic [COORD_W-1:0] src_y,
    input logic [7:0]         len,
    input logic [7:0]         seq
  );
    logic [31:0] h;
    h = '0;
    h[HDR_DST_X_LSB +: COORD_W] = dst_x;
    h[HDR_DST_Y_LSB +: COORD_W] = dst_y;
    h[HDR_SRC_X_LSB +: COORD_W] = src_x;
    h[HDR_SRC_Y_LSB +: COORD_W] = src_y;
    h[HDR_LEN_LSB   +: 8]       = len;
    h[HDR_SEQ_LSB   +: 8]       = seq;
    return h;
  endfunction

  // Low 32 bits of body flit number idx of packet seq.
  function automatic logic [31:0] make_body(
    input logic [7:0] idx,
    input logic [7:0] seq
  );
    return {BODY_PATTERN, seq, idx};
  endfunction

endpackage

// File: rtl/noc_test_rx.sv
// Receive checker: always ready, follows packet framing and counts complete,
// well-formed packets addressed to this node. Count saturates at 255.
module noc_test_rx
  import noc_test_node_pkg::*;
#(
  parameter int X_ID       = 0,
  parameter int Y_ID       = 0,
  parameter int DATA_WIDTH = NOC_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [DATA_WIDTH-1:0] flit_i,
  input  logic                  header_i,
  input  logic                  tail_i,
  output logic [7:0]            num_o
);

  logic       ready_q, ready_d;
  logic       in_pkt_q, in_pkt_d;
  logic       dest_ok_q, dest_ok_d;
  logic       good_q, good_d;
  logic [7:0] len_q, len_d;
  logic [7:0] seq_q, seq_d;
  logic [8:0] cnt_q, cnt_d;
  logic [7:0] num_q, num_d;

  logic       accept;
  logic       hdr_dest_ok;
  logic       body_ok;
  logic [8:0] cnt_next;
  logic       count_pkt;

  // Receive state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_q   <= 1'b0;
      in_pkt_q  <= 1'b0;
      dest_ok_q <= 1'b0;
      good_q    <= 1'b0;
      len_q     <= '0;
      seq_q     <= '0;
      cnt_q     <= '0;
      num_q     <= '0;
    end else begin
      ready_q   <= ready_d;
      in_pkt_q  <= in_pkt_d;
      dest_ok_q <= dest_ok_d;
      good_q    <= good_d;
      len_q     <= len_d;
      seq_q     <= seq_d;
      cnt_q     <= cnt_d;
      num_q     <= num_d;
    end
  end

  // Packet framing, body pattern check and saturating packet counter
  always_comb begin
    ready_d   = 1'b1;
    in_pkt_d  = in_pkt_q;
    dest_ok_d = dest_ok_q;
    good_d    = good_q;
    len_d     = len_q;
    seq_d     = seq_q;
    cnt_d     = cnt_q;
    num_d     = num_q;
    count_pkt = 1'b0;

    accept      = valid_i & ready_q;
    hdr_dest_ok = (flit_i[HDR_DST_X_LSB +: COORD_W] == COORD_W'(X_ID)) &&
                  (flit_i[HDR_DST_Y_LSB +: COORD_W] == COORD_W'(Y_ID));
    // cnt_q is the index this flit should carry; a count past 255 can never match
    body_ok  = (flit_i == DATA_WIDTH'(make_body(cnt_q[7:0], seq_q))) && !cnt_q[8];
    cnt_next = cnt_q + 9'd1;

    if (accept) begin
      if (header_i) begin
        // A header always (re)starts a packet, even in the middle of one
        dest_ok_d = hdr_dest_ok;
        len_d     = flit_i[HDR_LEN_LSB +: 8];
        seq_d     = flit_i[HDR_SEQ_LSB +: 8];
        cnt_d     = 9'd1;
        good_d    = 1'b1;
        if (tail_i) begin
          in_pkt_d  = 1'b0;
          count_pkt = hdr_dest_ok && (flit_i[HDR_LEN_LSB +: 8] == 8'd1);
        end else begin
          in_pkt_d = 1'b1;
        end
      end else if (in_pkt_q) begin
        cnt_d  = cnt_next;
        good_d = good_q & body_ok;
        if (tail_i) begin
          in_pkt_d  = 1'b0;
          count_pkt = dest_ok_q && good_q && body_ok && (cnt_next == {1'b0, len_q});
        end
      end
    end

    if (count_pkt && (num_q != 8'hFF)) begin
      num_d = num_q + 8'd1;
    end
  end

  assign ready_o = ready_q;
  assign num_o   = num_q;

endmodule

// File: rtl/noc_test_node.sv
// NoC test endpoint: TX generates NUM_PACKETS packets of PKT_LEN flits to
// (DEST_X_ID,DEST_Y_ID); RX counts good packets addressed to (X_ID,Y_ID).
// Handshake: a flit moves on a rising edge where valid & ready are both high;
// while valid is high and ready low, flit and markers stay unchanged, and
// valid is a function of registered state only (never of ready).
// noc_rst_n is an active-high asynchronous reset despite its name.
module noc_test_node
  import noc_test_node_pkg::*;
#(
  parameter int X_ID        = 0,
  parameter int Y_ID        = 0,
  parameter int DEST_X_ID   = 1,
  parameter int DEST_Y_ID   = 1,
  parameter int DATA_WIDTH  = NOC_DATA_WIDTH,
  parameter int PKT_LEN     = 4,
  parameter int NUM_PACKETS = 16,
  parameter int GAP         = 2
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst_n,
  input  logic                  receive_valid,
  output logic                  receive_ready,
  input  logic [DATA_WIDTH-1:0] receive_flit,
  input  logic                  receive_is_header,
  input  logic                  receive_is_tail,
  output logic                  sender_valid,
  input  logic                  sender_ready,
  output logic [DATA_WIDTH-1:0] sender_flit,
  output logic                  sender_is_header,
  output logic                  sender_is_tail,
  output logic [7:0]            receive_num
);

  localparam logic [7:0] LEN8 = 8'(PKT_LEN);
  localparam logic [7:0] LAST = 8'(PKT_LEN - 1);

  tx_state_e   state_q, state_d;
  logic [7:0]  seq_q, seq_d;
  logic [7:0]  idx_q, idx_d;
  logic [31:0] sent_q, sent_d;
  logic [31:0] gap_q, gap_d;
  logic [31:0] flit32;
  logic        pkt_done;

  // TX state register and counters
  always_ff @(posedge noc_clk or posedge noc_rst_n) begin
    if (noc_rst_n) begin
      state_q <= TX_IDLE;
      seq_q   <= '0;
      idx_q   <= '0;
      sent_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      idx_q   <= idx_d;
      sent_q  <= sent_d;
      gap_q   <= gap_d;
    end
  end

  // TX next state and flit outputs (outputs depend on state only)
  always_comb begin
    state_d          = state_q;
    seq_d            = seq_q;
    idx_d            = idx_q;
    sent_d           = sent_q;
    gap_d            = gap_q;
    pkt_done         = 1'b0;
    sender_valid     = 1'b0;
    sender_is_header = 1'b0;
    sender_is_tail   = 1'b0;
    flit32           = '0;

    case (state_q)
      TX_IDLE: begin
        state_d = (NUM_PACKETS > 0) ? TX_HEAD : TX_DONE;
      end
      TX_HEAD: begin
        sender_valid     = 1'b1;
        sender_is_header = 1'b1;
        sender_is_tail   = (PKT_LEN == 1);
        flit32 = make_header(COORD_W'(DEST_X_ID), COORD_W'(DEST_Y_ID),
                             COORD_W'(X_ID), COORD_W'(Y_ID), LEN8, seq_q);
        if (sender_ready) begin
          if (PKT_LEN > 1) begin
            state_d = TX_BODY;
            idx_d   = 8'd1;
          end else begin
            pkt_done = 1'b1;
          end
        end
      end
      TX_BODY: begin
        sender_valid   = 1'b1;
        sender_is_tail = (idx_q == LAST);
        flit32         = make_body(idx_q, seq_q);
        if (sender_ready) begin
          if (idx_q == LAST) begin
            pkt_done = 1'b1;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      TX_GAP: begin
        if (gap_q == 32'(GAP - 1)) begin
          state_d = (sent_q < 32'(NUM_PACKETS)) ? TX_HEAD : TX_DONE;
        end else begin
          gap_d = gap_q + 32'd1;
        end
      end
      default: begin
        state_d = TX_DONE;
      end
    endcase

    // Tail accepted: advance sequence (wraps at 255) and pick gap or next packet
    if (pkt_done) begin
      seq_d  = seq_q + 8'd1;
      sent_d = sent_q + 32'd1;
      gap_d  = '0;
      if (GAP > 0) begin
        state_d = TX_GAP;
      end else begin
        state_d = (sent_d < 32'(NUM_PACKETS)) ? TX_HEAD : TX_DONE;
      end
    end
  end

  assign sender_flit = DATA_WIDTH'(flit32);

  noc_test_rx #(
    .X_ID       (X_ID),
    .Y_ID       (Y_ID),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_rx (
    .clk_i    (noc_clk),
    .rst_i    (noc_rst_n),
    .valid_i  (receive_valid),
    .ready_o  (receive_ready),
    .flit_i   (receive_flit),
    .header_i (receive_is_header),
    .tail_i   (receive_is_tail),
    .num_o    (receive_num)
  );

endmodule

// File: tb/tb_noc_test_node.sv
// Bench for noc_test_node: a default-parameter node whose TX stream is
// scoreboarded, plus a node at (1,1) looped back on itself and later fed
// hand-built packets on its receive port.
`timescale 1ns/1ps
module tb_noc_test_node;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- node A (default parameters, TX under test) ----------------
  logic        a_sready;
  logic        a_svalid, a_shdr, a_stail;
  logic [31:0] a_sflit;
  logic        a_rready;
  logic [7:0]  a_rnum;

  noc_test_node u_dut (
    .noc_clk           (clk),
    .noc_rst_n         (rst),
    .receive_valid     (1'b0),
    .receive_ready     (a_rready),
    .receive_flit      (32'h0),
    .receive_is_header (1'b0),
    .receive_is_tail   (1'b0),
    .sender_valid      (a_svalid),
    .sender_ready      (a_sready),
    .sender_flit       (a_sflit),
    .sender_is_header  (a_shdr),
    .sender_is_tail    (a_stail),
    .receive_num       (a_rnum)
  );

  // ---------------- node L at (1,1): loopback or injected receive ----------------
  logic        loop_mode;
  logic        inj_valid, inj_hdr, inj_tail;
  logic [31:0] inj_flit;
  logic        l_svalid, l_shdr, l_stail, l_sready;
  logic [31:0] l_sflit;
  logic        l_rvalid, l_rhdr, l_rtail, l_rready;
  logic [31:0] l_rflit;
  logic [7:0]  l_rnum;

  assign l_rvalid = loop_mode ? l_svalid : inj_valid;
  assign l_rflit  = loop_mode ? l_sflit  : inj_flit;
  assign l_rhdr   = loop_mode ? l_shdr   : inj_hdr;
  assign l_rtail  = loop_mode ? l_stail  : inj_tail;
  assign l_sready = l_rready;

  noc_test_node #(
    .X_ID      (1),
    .Y_ID      (1),
    .DEST_X_ID (1),
    .DEST_Y_ID (1)
  ) u_loop (
    .noc_clk           (clk),
    .noc_rst_n         (rst),
    .receive_valid     (l_rvalid),
    .receive_ready     (l_rready),
    .receive_flit      (l_rflit),
    .receive_is_header (l_rhdr),
    .receive_is_tail   (l_rtail),
    .sender_valid      (l_svalid),
    .sender_ready      (l_sready),
    .sender_flit       (l_sflit),
    .sender_is_header  (l_shdr),
    .sender_is_tail    (l_stail),
    .receive_num       (l_rnum)
  );

  // ---------------- scoreboard: {tail, header, flit} ----------------
  logic [33:0] exp_q[$];
  logic        stall;
  logic [33:0] held;
  logic [33:0] got;
  logic [33:0] want;

  // Monitor on node A sender: pops on every handshake, checks hold on stalls
  always @(negedge clk) begin
    got = {a_stail, a_shdr, a_sflit};
    if (rst) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        checks++;
        if (!a_svalid || got != held) begin
          errors++;
          $display("FAIL hold_stable: got valid=%0b %h, required valid=1 %h", a_svalid, got, held);
        end
      end
      if (a_svalid && a_sready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_flit: got %h, required no flit", got);
        end else begin
          want = exp_q.pop_front();
          if (got != want) begin
            errors++;
            $display("FAIL tx_flit: got %h, required %h", got, want);
          end
        end
        stall = 1'b0;
      end else if (a_svalid) begin
        stall = 1'b1;
        held  = got;
      end else begin
        stall = 1'b0;
      end
    end
  end

  // ---------------- driver / helper tasks ----------------
  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, actual, required);
    end
  endtask

  // Full 16 x 4 stream of node A: header {seq,len=4,src(0,0),dst(1,1)}, bodies {A5A5,seq,i}
  task automatic push_tx(input int n_flits);
    logic [7:0] s;
    int n;
    n = 0;
    for (int p = 0; p < 16; p++) begin
      s = 8'(p);
      if (n < n_flits) exp_q.push_back({1'b0, 1'b1, s, 24'h04_0011});
      n++;
      for (int i = 1; i < 4; i++) begin
        if (n < n_flits) exp_q.push_back({(i == 3), 1'b0, 16'hA5A5, s, 8'(i)});
        n++;
      end
    end
  endtask

  task automatic wait_empty(input string name, input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d flits outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic toggle_until_empty(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk);
      #1 a_sready = ~a_sready;
      k++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL toggle_timeout: got %0d flits outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic put(input logic [31:0] f, input logic h, input logic t);
    @(negedge clk);
    inj_valid = 1'b1;
    inj_flit  = f;
    inj_hdr   = h;
    inj_tail  = t;
  endtask

  task automatic idle_inj();
    @(negedge clk);
    inj_valid = 1'b0;
    inj_flit  = '0;
    inj_hdr   = 1'b0;
    inj_tail  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst       = 1'b1;
    a_sready  = 1'b1;
    loop_mode = 1'b1;
    inj_valid = 1'b0;
    inj_flit  = '0;
    inj_hdr   = 1'b0;
    inj_tail  = 1'b0;
    stall     = 1'b0;
    held      = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sender_valid", 32'(a_svalid), 32'd0);
    chk("rst_sender_flit", a_sflit, 32'd0);
    chk("rst_markers", {30'd0, a_shdr, a_stail}, 32'd0);
    chk("rst_receive_ready", 32'(a_rready), 32'd0);
    chk("rst_receive_num", 32'(a_rnum), 32'd0);
    chk("rst_loop_num", 32'(l_rnum), 32'd0);

    // Continuous ready: 64 flits, first header 0x0004_0011, then idle
    push_tx(64);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_release", 32'(a_rready), 32'd1);
    wait_empty("stream", 400);
    repeat (30) @(negedge clk);
    chk("idle_after_done", 32'(a_svalid), 32'd0);
    chk("loop_num_16", 32'(l_rnum), 32'd16);

    // Ready toggling every cycle: same stream, held stable while stalled
    do_reset();
    push_tx(64);
    a_sready = 1'b0;
    rst = 1'b0;
    toggle_until_empty(600);
    a_sready = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_after_toggle", 32'(a_svalid), 32'd0);
    chk("loop_num_16_again", 32'(l_rnum), 32'd16);

    // Injected packets into node (1,1)
    @(negedge clk);
    loop_mode = 1'b0;
    // wrong destination (0,1)
    put(32'h0504_3210, 1'b1, 1'b0);
    put(32'hA5A5_0501, 1'b0, 1'b0);
    put(32'hA5A5_0502, 1'b0, 1'b0);
    put(32'hA5A5_0503, 1'b0, 1'b1);
    idle_inj();
    chk("wrong_dest", 32'(l_rnum), 32'd16);
    // corrupt second body flit
    put(32'h0504_3211, 1'b1, 1'b0);
    put(32'hA5A5_0501, 1'b0, 1'b0);
    put(32'hA5A4_0502, 1'b0, 1'b0);
    put(32'hA5A5_0503, 1'b0, 1'b1);
    idle_inj();
    chk("corrupt_body", 32'(l_rnum), 32'd16);
    // good packet
    put(32'h0504_3211, 1'b1, 1'b0);
    put(32'hA5A5_0501, 1'b0, 1'b0);
    put(32'hA5A5_0502, 1'b0, 1'b0);
    put(32'hA5A5_0503, 1'b0, 1'b1);
    idle_inj();
    chk("good_packet", 32'(l_rnum), 32'd17);
    // single-flit packet
    put(32'h0901_3211, 1'b1, 1'b1);
    idle_inj();
    chk("single_flit", 32'(l_rnum), 32'd18);
    // orphan tail with no header
    put(32'hA5A5_0901, 1'b0, 1'b1);
    idle_inj();
    chk("orphan_flit", 32'(l_rnum), 32'd18);
    // header mid-packet restarts
    put(32'h0504_3211, 1'b1, 1'b0);
    put(32'hA5A5_0501, 1'b0, 1'b0);
    put(32'h0604_3211, 1'b1, 1'b0);
    put(32'hA5A5_0601, 1'b0, 1'b0);
    put(32'hA5A5_0602, 1'b0, 1'b0);
    put(32'hA5A5_0603, 1'b0, 1'b1);
    idle_inj();
    chk("header_restart", 32'(l_rnum), 32'd19);
    // short packet: len 4 but tail on third flit
    put(32'h0704_3211, 1'b1, 1'b0);
    put(32'hA5A5_0701, 1'b0, 1'b0);
    put(32'hA5A5_0702, 1'b0, 1'b1);
    idle_inj();
    chk("short_packet", 32'(l_rnum), 32'd19);
    // header+tail but declared length 2
    put(32'h0802_3211, 1'b1, 1'b1);
    idle_inj();
    chk("single_bad_len", 32'(l_rnum), 32'd19);

    // 300 good single-flit packets: saturation at 255
    for (int k = 1; k <= 300; k++) begin
      put(32'h0001_3211, 1'b1, 1'b1);
      if (k == 235 || k == 236 || k == 300) begin
        idle_inj();
        chk($sformatf("saturate_%0d", k), 32'(l_rnum), (k == 235) ? 32'd254 : 32'd255);
      end
    end
    idle_inj();

    // Reset while flit 2 of the third packet (seq 2) is presented
    do_reset();
    a_sready = 1'b1;
    push_tx(11);
    rst = 1'b0;
    wait_empty("pre_abort", 200);
    rst = 1'b1;
    #1;
    chk("abort_sender_valid", 32'(a_svalid), 32'd0);
    chk("abort_sender_flit", a_sflit, 32'd0);
    chk("abort_markers", {30'd0, a_shdr, a_stail}, 32'd0);
    chk("abort_receive_num", 32'(l_rnum), 32'd0);
    repeat (2) @(negedge clk);
    push_tx(64);
    rst = 1'b0;
    wait_empty("restart", 400);
    repeat (10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
